// File: rtl/token_pkg.sv
// token_pkg: shared constants and types for the token rate meter.
//   DEFAULT_WINDOW     - default cycles per measurement window
//   DEFAULT_FIFO_DEPTH - default result queue depth
//   DROP_W             - width of the saturating drop counter
//   drop_cnt_t         - drop counter type
//   sat_inc            - saturating increment for drop_cnt_t
package token_pkg;

    localparam int unsigned DEFAULT_WINDOW     = 16;
    localparam int unsigned DEFAULT_FIFO_DEPTH = 2;
    localparam int unsigned DROP_W             = 8;

    typedef logic [DROP_W-1:0] drop_cnt_t;

    function automatic drop_cnt_t sat_inc(input drop_cnt_t v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/token_rate_meter_if.sv
// token_rate_meter_if: valid/ready result channel of the token rate meter.
//   out_valid - head of the result queue is valid (master -> slave)
//   out_ready - consumer accepts the head          (slave -> master)
//   out_count - token count of the oldest window   (master -> slave)
interface token_rate_meter_if #(
    parameter int unsigned CNT_W = 5
) ();

    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_count;

    modport master (
        output out_valid,
        output out_count,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_count,
        output out_ready
    );

endinterface

// File: rtl/token_fifo.sv
// token_fifo: synchronous FIFO with asynchronous active-low reset.
//   clk, rst_n - clock, async active-low reset
//   push, din  - write request and data (accepted when not full, or full with pop)
//   pop        - read request (ignored when empty)
//   dout       - head entry
//   empty/full - occupancy flags
module token_fifo #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    typedef logic [PTR_W-1:0] ptr_t;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    ptr_t             wr_ptr_q, wr_ptr_d;
    ptr_t             rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             do_push, do_pop;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty = (occ_q == '0);
    assign full  = (occ_q == OCC_W'(DEPTH));
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop & ~empty;
        // When full, a simultaneous pop frees the slot the push lands in.
        do_push  = push & (~full | do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

endmodule

// File: rtl/token_rate_meter.sv
// token_rate_meter: counts '1' tokens over windows of WINDOW cycles and queues
// each window's count on a valid/ready channel, tracking windows lost to
// back-pressure.
//   clk, rst_n  - clock, async active-low reset
//   a           - serial token input (1 = token this cycle)
//   clear       - synchronous window restart (queue and drop stats kept)
//   out_if      - result channel (out_valid/out_ready/out_count)
//   overflow    - sticky: at least one window was dropped
//   drop_count  - saturating number of dropped windows
//   peak_count  - max accepted result since reset/clear
//                 (only when TOKEN_RATE_METER_PEAK_EN is defined)
module token_rate_meter
    import token_pkg::*;
#(
    parameter int unsigned WINDOW     = DEFAULT_WINDOW,
    parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       a,
    input  logic                       clear,
    token_rate_meter_if.master         out_if,
    output logic                       overflow,
    output drop_cnt_t                  drop_count
`ifdef TOKEN_RATE_METER_PEAK_EN
    ,
    output logic [$clog2(WINDOW+1)-1:0] peak_count
`endif
);

    localparam int unsigned CNT_W = $clog2(WINDOW + 1);
    localparam int unsigned POS_W = $clog2(WINDOW);

    logic [POS_W-1:0] pos_q, pos_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] result;
    logic [CNT_W-1:0] fifo_dout;
    logic             overflow_q, overflow_d;
    drop_cnt_t        drop_q, drop_d;
    logic             win_end, pop, push, drop;
    logic             fifo_empty, fifo_full;

    always_comb begin
        win_end = (pos_q == POS_W'(WINDOW - 1));
        // Includes the token sampled on the window's last cycle.
        result  = acc_q + CNT_W'(a);
        pop     = ~fifo_empty & out_if.out_ready;
        // clear on a window-end cycle suppresses both push and drop.
        push    = win_end & ~clear & (~fifo_full | pop);
        drop    = win_end & ~clear & fifo_full & ~pop;

        pos_d   = (clear | win_end) ? '0 : pos_q + 1'b1;
        acc_d   = (clear | win_end) ? '0 : result;

        overflow_d = overflow_q | drop;
        drop_d     = drop ? sat_inc(drop_q) : drop_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q      <= '0;
            acc_q      <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            pos_q      <= pos_d;
            acc_q      <= acc_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    token_fifo #(
        .WIDTH (CNT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (result),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign out_if.out_valid = ~fifo_empty;
    assign out_if.out_count = fifo_dout;
    assign overflow         = overflow_q;
    assign drop_count       = drop_q;

`ifdef TOKEN_RATE_METER_PEAK_EN
    logic [CNT_W-1:0] peak_q, peak_d;

    always_comb begin
        peak_d = peak_q;
        if (clear) begin
            peak_d = '0;
        end else if (push && (result > peak_q)) begin
            peak_d = result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak_count = peak_q;
`endif

endmodule

// File: tb/tb_token_rate_meter.sv
// tb_token_rate_meter: randomized and directed stimulus; a reference model
// pushes expected window results into a queue, a monitor pops and compares on
// each accepted output. Build with TOKEN_RATE_METER_PEAK_EN to cover peak_count.
module tb_token_rate_meter;
    import token_pkg::*;

    localparam int WINDOW = 4;
    localparam int DEPTH  = 2;
    localparam int CNT_W  = $clog2(WINDOW + 1);
    localparam int DROP_MAX = (1 << DROP_W) - 1;

    logic      clk   = 1'b0;
    logic      rst_n = 1'b1;
    logic      a     = 1'b0;
    logic      clear = 1'b0;
    logic      overflow;
    drop_cnt_t drop_count;
`ifdef TOKEN_RATE_METER_PEAK_EN
    logic [CNT_W-1:0] peak_count;
`endif

    token_rate_meter_if #(.CNT_W(CNT_W)) out_if ();

    token_rate_meter #(
        .WINDOW     (WINDOW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a),
        .clear      (clear),
        .out_if     (out_if),
        .overflow   (overflow),
        .drop_count (drop_count)
`ifdef TOKEN_RATE_METER_PEAK_EN
        ,
        .peak_count (peak_count)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int pops     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: collects the window's samples, sums them at window end,
    // queues the sum if the bounded result queue has room, otherwise drops it.
    int  win_tok[$];
    int  exp_q[$];
    int  m_drops;
    bit  m_ovf;
    int  m_peak;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_tok.delete();
            exp_q.delete();
            m_drops = 0;
            m_ovf   = 1'b0;
            m_peak  = 0;
        end else if (clear) begin
            win_tok.delete();
            m_peak = 0;
        end else begin
            win_tok.push_back(int'(a));
            if (win_tok.size() == WINDOW) begin
                int res;
                res = win_tok.sum();
                win_tok.delete();
                if (exp_q.size() < DEPTH) begin
                    exp_q.push_back(res);
                    if (res > m_peak) m_peak = res;
                end else begin
                    m_ovf   = 1'b1;
                    m_drops = (m_drops < DROP_MAX) ? m_drops + 1 : DROP_MAX;
                end
            end
        end
    end

    // Monitor: compares the presented head and pops on a handshake that the
    // next rising edge will complete.
    always @(negedge clk) begin
        if (rst_n) begin
            check("out_valid", 32'(out_if.out_valid), 32'(exp_q.size() != 0));
            if (out_if.out_valid && exp_q.size() != 0) begin
                check("out_count", 32'(out_if.out_count), 32'(exp_q[0]));
            end
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("drop_count", 32'(drop_count), 32'(m_drops));
`ifdef TOKEN_RATE_METER_PEAK_EN
            check("peak_count", 32'(peak_count), 32'(m_peak));
`endif
            if (out_if.out_valid && out_if.out_ready && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                pops++;
            end
        end
    end

    task automatic cyc(input logic ai, input logic ci, input logic ri);
        a               = ai;
        clear           = ci;
        out_if.out_ready = ri;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int p0;
        out_if.out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(out_if.out_valid), 0);
        check("rst_count", 32'(out_if.out_count), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_drops", 32'(drop_count), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Constant tokens, always ready.
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 1'b1);
        check("const_overflow", 32'(overflow), 0);

        // Halved stream 0101.
        do_reset();
        for (int i = 0; i < 16; i++) cyc(1'(i % 2), 1'b0, 1'b1);
`ifdef TOKEN_RATE_METER_PEAK_EN
        check("halved_peak", 32'(peak_count), 2);
`endif

        // Back-pressure for three windows: one drop.
        do_reset();
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 1'b0);
        check("bp_overflow", 32'(overflow), 1);
        check("bp_drops", 32'(drop_count), 1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1);

        // Full queue, ready on the window-end cycle: no drop, three in order.
        do_reset();
        for (int i = 0; i < 11; i++) cyc(1'b1, 1'b0, 1'b0);
        p0 = pops;
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        check("full_pop_drops", 32'(drop_count), 0);
        check("full_pop_delivered", 32'(pops - p0), 3);

        // Clear mid-window with a result already queued.
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0);
        check("clear_drops", 32'(drop_count), 0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1);

        // Asynchronous reset mid-window with one queued result.
        do_reset();
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("async_valid", 32'(out_if.out_valid), 0);
        check("async_drops", 32'(drop_count), 0);
        check("async_overflow", 32'(overflow), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            check("restart_latency", 32'(out_if.out_valid), 32'(i == 3));
        end

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0),
                1'($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/token_rate_meter.md
Name: token_rate_meter

Overview:
- Downstream consumer of the serial token stream produced by the token-halving stage.
- Counts '1' tokens over fixed windows of WINDOW cycles.
- Queues each window's count in a small FIFO and presents it on a valid/ready output.
- Reports windows lost to back-pressure, so the bench and system can check token rate (e.g. that halved streams carry half the tokens).

Parameters:
- WINDOW, 16, cycles per measurement window; legal range >= 2.
- CNT_W, $clog2(WINDOW+1), width of a window count; derived, not overridden.
- FIFO_DEPTH, 2, result queue entries; legal range >= 1.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- a  in  1  serial token input; 1 = token this cycle.
- clear  in  1  synchronous window restart.
- out_valid  out  1  head of the result FIFO is valid.
- out_ready  in  1  consumer accepts the head.
- out_count  out  CNT_W  token count of the oldest queued window.
- overflow  out  1  sticky: at least one window was dropped.
- drop_count  out  DROP_W  number of dropped windows; saturates at all-ones.

Behaviour:
- Reset:
  - Asserting rst_n=0 immediately and asynchronously clears all state.
  - Cleared state: window position pos, accumulator acc, FIFO pointers and occupancy, overflow, drop_count.
  - All outputs read 0 while in reset.
- Window counting:
  - pos increments every cycle and wraps from WINDOW-1 to 0.
  - When pos != WINDOW-1: acc <= acc + a.
  - At pos == WINDOW-1 (window end): result = acc + a (includes the last cycle's token); result is pushed; acc <= 0.
  - Maximum result is WINDOW, so no wrap is possible at width CNT_W.
- Latency: a window ending at sampled edge k with an empty FIFO gives out_valid=1 and out_count=result after edge k.
- FIFO occupancy states:
  - EMPTY: out_valid=0.
  - PARTIAL: out_valid=1.
  - FULL: out_valid=1.
  - Transitions come from push (window end) and pop (out_valid & out_ready).
  - out_count is stable while out_valid=1 and out_ready=0.
- Push while FULL without a pop: the result is discarded, overflow <= 1, and drop_count increments (saturating).
- Push and pop in the same cycle while FULL: the pop frees a slot and the push is accepted. There is no drop and occupancy is unchanged.
- Push and pop in the same cycle while PARTIAL: occupancy is unchanged.
- clear=1:
  - pos <= 0, acc <= 0.
  - If the same cycle is a window end, clear wins: no push and no drop.
  - clear does not flush the FIFO and does not reset overflow or drop_count. Only rst_n resets those.
- Reset mid-operation: queued results are lost and out_valid falls asynchronously. Counting restarts at pos=0 after release.
- out_ready while EMPTY is ignored.

Optional Feature:
- Macro TOKEN_RATE_METER_PEAK_EN.
- Defined: adds output peak_count [CNT_W]. It holds the maximum of all results accepted into the FIFO since reset or since the last clear; both reset it to 0. Dropped windows do not update it.
- Not defined: no peak_count port and no peak register.

Decomposition:
- Package token_pkg:
  - DEFAULT_WINDOW=16, DEFAULT_FIFO_DEPTH=2, DROP_W=8.
  - typedef drop_cnt_t (logic [DROP_W-1:0]).
- Sub-module token_fifo:
  - Parameterized width and depth; synchronous FIFO with asynchronous active-low reset.
  - Ports: push, pop, din, dout, empty, full.
- token_rate_meter contains the window counter, accumulator, drop and peak logic.

Test Plan (WINDOW=4, FIFO_DEPTH=2):
- a=1 constantly, out_ready=1 → out_count=4 once per 4 cycles, out_valid for one cycle after each window end; overflow=0.
- a=0101 repeating (halved 1111 stream), out_ready=1 → every result is 2; with PEAK_EN, peak_count=2.
- a=1 constantly, out_ready=0 for 3 windows, then out_ready=1 → pops 4,4; overflow=1, drop_count=1.
- FIFO FULL, out_ready=1 on the window-end cycle → no drop; drop_count unchanged; 3 results delivered in order.
- Two tokens at pos 0–1, clear at pos 2 → no result for that window; next full window of a=1 yields 4; queued results are unaffected.
- rst_n=0 mid-window with one queued result → out_valid=0 immediately without a clk edge; drop_count=0; first result after release arrives 4 cycles later.
